trigger_source_arbiter: RTL and testbench

Arbitrates the four trigger sources (RF, PPS1, PPS2, software) into the single trigger-request input of the buffer manager in the 250 MHz domain. Each source's edges are latched as pending requests, and one request is granted at a time by round-robin. Grants are blocked while the buffer manager reports dead or `disable_i` is high. After every issued trigger, a programmable holdoff is enforced, and per-source issued/dropped counts are kept for the scaler readout.

---
 rtl/trigger_source_arbiter_if.sv | 28 ++
 rtl/trigger_source_arbiter.sv | 127 ++++++++++++
 tb/tb_trigger_source_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_source_arbiter_if.sv
// Bundle of trigger-arbiter controls and status between the trigger front end and the buffer manager.
// The slave modport is the arbiter's view; master is the driver/observer side.
interface trigger_source_arbiter_if #(
    parameter int NUM_SRC  = 4,
    parameter int CNT_BITS = 16
);
    logic [NUM_SRC-1:0]          trig_i;
    logic [NUM_SRC-1:0]          mask_i;
    logic                        disable_i;
    logic                        dead_i;
    logic [7:0]                  holdoff_i;
    logic                        cnt_clr_i;
    logic                        trig_o;
    logic [NUM_SRC-1:0]          source_o;
    logic [NUM_SRC-1:0]          pending_o;
    logic [NUM_SRC*CNT_BITS-1:0] issued_cnt_o;
    logic [NUM_SRC*CNT_BITS-1:0] drop_cnt_o;

    modport master (
        output trig_i, mask_i, disable_i, dead_i, holdoff_i, cnt_clr_i,
        input  trig_o, source_o, pending_o, issued_cnt_o, drop_cnt_o
    );

    modport slave (
        input  trig_i, mask_i, disable_i, dead_i, holdoff_i, cnt_clr_i,
        output trig_o, source_o, pending_o, issued_cnt_o, drop_cnt_o
    );
endinterface

// File: rtl/trigger_source_arbiter.sv
// Latches trigger-source edges as pending requests and issues one-cycle trigger requests
// by round-robin, with a programmable holdoff and saturating per-source scalers.
module trigger_source_arbiter #(
    parameter int NUM_SRC  = 4,
    parameter int CNT_BITS = 16
) (
    input  logic                      clk250_i,
    input  logic                      rst_i,
    trigger_source_arbiter_if.slave   bus
);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] HOLDOFF = 2'd2;

    logic [1:0]          state;
    logic [7:0]          hold_cnt;
    logic [NUM_SRC-1:0]  trig_q;
    logic [NUM_SRC-1:0]  pending;
    logic [NUM_SRC-1:0]  rise;
    logic [NUM_SRC-1:0]  edge_ok;
    logic [NUM_SRC-1:0]  grant_vec;
    logic [NUM_SRC-1:0]  drop_vec;
    logic [NUM_SRC-1:0]  source_r;
    logic [IDX_W-1:0]    last;
    logic [IDX_W-1:0]    winner;
    logic                found;
    logic                grant;
    logic                trig_r;
    int                  sel;
    logic [CNT_BITS-1:0] issued_cnt [NUM_SRC];
    logic [CNT_BITS-1:0] drop_cnt   [NUM_SRC];

    assign rise    = bus.trig_i & ~trig_q;
    assign edge_ok = rise & ~bus.mask_i & {NUM_SRC{~bus.disable_i}};

    // Search starts just after the last winner and wraps, giving rotating priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sel    = 0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            sel = (int'(last) + i) % NUM_SRC;
            if (!found && pending[IDX_W'(sel)]) begin
                winner = IDX_W'(sel);
                found  = 1'b1;
            end
        end
    end

    assign grant     = (state == IDLE) && (|pending) && !bus.dead_i && !bus.disable_i;
    assign grant_vec = grant ? (NUM_SRC'(1) << winner) : '0;
    assign drop_vec  = edge_ok & pending & ~grant_vec;

    // A new edge in the grant cycle re-arms the request rather than counting as a drop.
    always_ff @(posedge clk250_i) begin
        if (rst_i) begin
            trig_q  <= '0;
            pending <= '0;
        end else begin
            trig_q <= bus.trig_i;
            if (bus.disable_i)
                pending <= '0;
            else
                pending <= (pending & ~grant_vec) | edge_ok;
        end
    end

    always_ff @(posedge clk250_i) begin
        if (rst_i) begin
            state    <= IDLE;
            trig_r   <= 1'b0;
            source_r <= '0;
            last     <= IDX_W'(NUM_SRC - 1);
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state    <= ISSUE;
                        trig_r   <= 1'b1;
                        source_r <= grant_vec;
                        last     <= winner;
                    end
                end
                ISSUE: begin
                    trig_r   <= 1'b0;
                    hold_cnt <= bus.holdoff_i;
                    state    <= (bus.holdoff_i != 8'd0) ? HOLDOFF : IDLE;
                end
                HOLDOFF: begin
                    hold_cnt <= hold_cnt - 8'd1;
                    if (hold_cnt == 8'd1)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clear takes precedence over any same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk250_i) begin
        if (rst_i || bus.cnt_clr_i) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                issued_cnt[k] <= '0;
                drop_cnt[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (grant_vec[k] && (issued_cnt[k] != '1))
                    issued_cnt[k] <= issued_cnt[k] + CNT_BITS'(1);
                if (drop_vec[k] && (drop_cnt[k] != '1))
                    drop_cnt[k] <= drop_cnt[k] + CNT_BITS'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_pack
        assign bus.issued_cnt_o[k*CNT_BITS +: CNT_BITS] = issued_cnt[k];
        assign bus.drop_cnt_o[k*CNT_BITS +: CNT_BITS]   = drop_cnt[k];
    end

    assign bus.trig_o    = trig_r;
    assign bus.source_o  = source_r;
    assign bus.pending_o = pending;
endmodule

// File: tb/tb_trigger_source_arbiter.sv
// Scoreboard bench for trigger_source_arbiter: a cycle-level reference model predicts each
// trigger pulse (cycle, source, issued count) and a negedge monitor checks the DUT against it.
module tb_trigger_source_arbiter;
    localparam int NS  = 4;
    localparam int CB  = 4;
    localparam int MAXC = (1 << CB) - 1;

    typedef struct {
        int stamp;
        int src;
        int cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   e;
    exp_t q[$];

    logic [NS-1:0] m_pending;
    logic [NS-1:0] m_prev;
    logic [NS-1:0] m_source;
    int            m_issued [NS];
    int            m_drop   [NS];
    int            m_last;
    int            m_ready;
    bit            m_issue;

    trigger_source_arbiter_if #(.NUM_SRC(NS), .CNT_BITS(CB)) bus ();

    trigger_source_arbiter #(.NUM_SRC(NS), .CNT_BITS(CB)) dut (
        .clk250_i (clk),
        .rst_i    (rst),
        .bus      (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, e);
        end
    endtask

    // Reference model: state advances once per rising edge using the inputs sampled there.
    task automatic run_model();
        logic [NS-1:0] rise;
        logic [NS-1:0] eff;
        logic [NS-1:0] gbit;
        int            w;
        bit            idle_now;
        bit            grant;
        bit            hit;
        int            k;
        e++;
        if (rst) begin
            m_pending = '0;
            m_prev    = '0;
            m_source  = '0;
            m_last    = NS - 1;
            m_ready   = 0;
            m_issue   = 0;
            for (int i = 0; i < NS; i++) begin
                m_issued[i] = 0;
                m_drop[i]   = 0;
            end
            return;
        end
        rise   = bus.trig_i & ~m_prev;
        m_prev = bus.trig_i;
        idle_now = !m_issue && (e >= m_ready);
        if (m_issue) begin
            m_ready = e + 1 + int'(bus.holdoff_i);
            m_issue = 0;
        end
        grant = idle_now && (m_pending != 0) && !bus.dead_i && !bus.disable_i;
        gbit = '0;
        w    = 0;
        hit  = 0;
        if (grant) begin
            for (int off = 1; off <= NS; off++) begin
                k = (m_last + off) % NS;
                if (!hit && m_pending[k]) begin
                    w   = k;
                    hit = 1;
                end
            end
            gbit[w] = 1'b1;
        end
        eff = bus.disable_i ? '0 : (rise & ~bus.mask_i);
        for (int i = 0; i < NS; i++)
            if (eff[i] && m_pending[i] && !gbit[i] && m_drop[i] < MAXC)
                m_drop[i]++;
        m_pending = bus.disable_i ? '0 : ((m_pending & ~gbit) | eff);
        if (grant) begin
            if (m_issued[w] < MAXC)
                m_issued[w]++;
            m_last   = w;
            m_source = gbit;
            m_issue  = 1;
        end
        if (bus.cnt_clr_i) begin
            for (int i = 0; i < NS; i++) begin
                m_issued[i] = 0;
                m_drop[i]   = 0;
            end
        end
        if (grant)
            q.push_back('{stamp: e, src: w, cnt: m_issued[w]});
    endtask

    task automatic tick();
        @(posedge clk);
        run_model();
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic apply_stimulus(input logic [NS-1:0] t);
        bus.trig_i = t;
        tick();
        bus.trig_i = '0;
        tick();
    endtask

    task automatic check_output(input string tag);
        check({tag, ".pending"}, int'(bus.pending_o), int'(m_pending));
        check({tag, ".source"},  int'(bus.source_o),  int'(m_source));
        for (int k = 0; k < NS; k++) begin
            check($sformatf("%s.issued%0d", tag, k), int'(bus.issued_cnt_o[k*CB +: CB]), m_issued[k]);
            check($sformatf("%s.drop%0d",   tag, k), int'(bus.drop_cnt_o[k*CB +: CB]),   m_drop[k]);
        end
    endtask

    // Monitor: every trig_o pulse must match the oldest prediction; stale predictions are misses.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].stamp < e) begin
            checks++;
            failures++;
            $display("[TB] FAIL missed_trigger actual=none expected=src%0d@%0d", q[0].src, q[0].stamp);
            void'(q.pop_front());
        end
        if (bus.trig_o === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL spurious_trigger actual=src_onehot%0h expected=none (cycle %0d)",
                         bus.source_o, e);
            end else begin
                exp_t x;
                x = q.pop_front();
                check("trig.cycle",  e, x.stamp);
                check("trig.source", int'(bus.source_o), 1 << x.src);
                check("trig.issued", int'(bus.issued_cnt_o[x.src*CB +: CB]), x.cnt);
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        e         = 0;
        m_pending = '0;
        m_prev    = '0;
        m_source  = '0;
        m_last    = NS - 1;
        m_ready   = 0;
        m_issue   = 0;
        for (int i = 0; i < NS; i++) begin
            m_issued[i] = 0;
            m_drop[i]   = 0;
        end
        rst           = 1'b1;
        bus.trig_i    = '0;
        bus.mask_i    = '0;
        bus.disable_i = 1'b0;
        bus.dead_i    = 1'b0;
        bus.holdoff_i = 8'd0;
        bus.cnt_clr_i = 1'b0;
        idle_cycles(3);
        rst = 1'b0;
        tick();
        check_output("reset");
        check("reset.trig", int'(bus.trig_o), 0);

        $display("[TB] single edge");
        apply_stimulus(4'b0001);
        idle_cycles(4);
        check_output("single");

        $display("[TB] round robin");
        bus.holdoff_i = 8'd3;
        apply_stimulus(4'b1111);
        idle_cycles(25);
        check_output("rr");

        $display("[TB] coalescing");
        bus.holdoff_i = 8'd0;
        bus.dead_i    = 1'b1;
        repeat (3) apply_stimulus(4'b0100);
        check_output("coalesce.dead");
        bus.dead_i = 1'b0;
        idle_cycles(6);
        check_output("coalesce.release");

        $display("[TB] mask and disable");
        bus.mask_i = 4'b1000;
        apply_stimulus(4'b1000);
        idle_cycles(3);
        check_output("mask");
        bus.mask_i = '0;
        bus.dead_i = 1'b1;
        apply_stimulus(4'b0001);
        check_output("disable.before");
        bus.disable_i = 1'b1;
        tick();
        bus.dead_i = 1'b0;
        idle_cycles(4);
        bus.disable_i = 1'b0;
        idle_cycles(4);
        check_output("disable.after");

        $display("[TB] saturation and clear");
        bus.dead_i = 1'b1;
        repeat (20) apply_stimulus(4'b0010);
        check_output("saturate");
        bus.trig_i    = 4'b0010;
        bus.cnt_clr_i = 1'b1;
        tick();
        bus.trig_i    = '0;
        bus.cnt_clr_i = 1'b0;
        tick();
        check_output("clear");
        bus.dead_i = 1'b0;
        idle_cycles(5);

        $display("[TB] reset mid holdoff");
        bus.holdoff_i = 8'd200;
        apply_stimulus(4'b0100);
        idle_cycles(51);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("midreset");
        check("midreset.trig", int'(bus.trig_o), 0);
        bus.holdoff_i = 8'd0;
        apply_stimulus(4'b0001);
        idle_cycles(4);
        check_output("after_reset");

        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            bus.trig_i    = NS'($urandom & $urandom & $urandom);
            bus.dead_i    = ($urandom_range(0, 3) == 0);
            bus.disable_i = ($urandom_range(0, 31) == 0);
            bus.cnt_clr_i = ($urandom_range(0, 199) == 0);
            bus.holdoff_i = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 63) == 0)
                bus.mask_i = NS'($urandom & $urandom);
            tick();
            if (c % 500 == 499)
                check_output("random");
        end
        bus.trig_i    = '0;
        bus.dead_i    = 1'b0;
        bus.disable_i = 1'b0;
        bus.cnt_clr_i = 1'b0;
        bus.mask_i    = '0;
        idle_cycles(40);
        check_output("final");
        check("final.queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
